// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator.
// Decodes instr[31:7] into an XLEN-bit immediate and carries a sideband tag.
// Results pass through PIPE_STAGES elastic valid/ready registers, with flush support.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ExtenSel,
  input  logic [24:0]      imm_in,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int N = PIPE_STAGES;

  localparam logic [2:0] SEL_I = 3'b000;
  localparam logic [2:0] SEL_S = 3'b001;
  localparam logic [2:0] SEL_B = 3'b010;
  localparam logic [2:0] SEL_U = 3'b011;
  localparam logic [2:0] SEL_J = 3'b100;
  localparam logic [2:0] SEL_Z = 3'b101;

  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;

  // Each format is built as a correctly extended 32-bit value; bit 31 then fills the upper XLEN bits.
  always_comb begin
    imm32       = '0;
    dec_illegal = 1'b0;
    case (ExtenSel)
      SEL_I: imm32 = {{20{imm_in[24]}}, imm_in[24:13]};
      SEL_S: imm32 = {{20{imm_in[24]}}, imm_in[24:18], imm_in[4:0]};
      SEL_B: imm32 = {{19{imm_in[24]}}, imm_in[24], imm_in[0], imm_in[23:18], imm_in[4:1], 1'b0};
      SEL_U: imm32 = {imm_in[24:5], 12'b0};
      SEL_J: imm32 = {{11{imm_in[24]}}, imm_in[24], imm_in[12:5], imm_in[13], imm_in[23:14], 1'b0};
      SEL_Z: imm32 = {27'b0, imm_in[12:8]};
      default: begin
        imm32       = '0;
        dec_illegal = 1'b1;
      end
    endcase
    dec_imm        = {XLEN{imm32[31]}};
    dec_imm[31:0]  = imm32;
  end

  logic [N-1:0]            valid_q, valid_d;
  logic [N-1:0]            illegal_q, illegal_d;
  logic [N-1:0][XLEN-1:0]  imm_q, imm_d;
  logic [N-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [N-1:0]            rdy;
  logic [N-1:0]            load;

  // Ready ripples backwards from out_ready; a stage loads when it is empty or its consumer takes its data.
  always_comb begin
    rdy      = '0;
    load     = '0;
    rdy[N-1] = out_ready;
    for (int i = N - 2; i >= 0; i--) begin
      rdy[i] = !valid_q[i+1] || rdy[i+1];
    end
    for (int i = 0; i < N; i++) begin
      load[i] = !valid_q[i] || rdy[i];
    end
  end

  assign in_ready = load[0];

  // Next-state for every stage: the first takes the decoded request, later ones take their predecessor.
  always_comb begin
    valid_d   = valid_q;
    illegal_d = illegal_q;
    imm_d     = imm_q;
    tag_d     = tag_q;
    if (load[0]) begin
      valid_d[0]   = in_valid;
      illegal_d[0] = dec_illegal;
      imm_d[0]     = dec_imm;
      tag_d[0]     = in_tag;
    end
    for (int i = 1; i < N; i++) begin
      if (load[i]) begin
        valid_d[i]   = valid_q[i-1];
        illegal_d[i] = illegal_q[i-1];
        imm_d[i]     = imm_q[i-1];
        tag_d[i]     = tag_q[i-1];
      end
    end
    if (flush) begin
      valid_d = '0;
    end
  end

  // Stage registers; reset clears payload too so the outputs read zero while held in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= '0;
      illegal_q <= '0;
      imm_q     <= '0;
      tag_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      imm_q     <= imm_d;
      tag_q     <= tag_d;
    end
  end

  assign out_valid   = valid_q[N-1];
  assign out_illegal = illegal_q[N-1];
  assign out_imm     = imm_q[N-1];
  assign out_tag     = tag_q[N-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives a 32-bit single-stage instance and a 64-bit two-stage instance,
// checking them against an ISA-level immediate model and a queue-based pipeline model.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [2:0]  a_sel;
  logic [24:0] a_imm_in;
  logic [4:0]  a_in_tag, a_out_tag;
  logic [31:0] a_out_imm;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [2:0]  b_sel;
  logic [24:0] b_imm_in;
  logic [4:0]  b_in_tag, b_out_tag;
  logic [63:0] b_out_imm;

  imm_gen_pipe #(.XLEN(32), .PIPE_STAGES(1), .TAG_W(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .ExtenSel(a_sel), .imm_in(a_imm_in), .in_tag(a_in_tag), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_imm(a_out_imm), .out_tag(a_out_tag), .out_illegal(a_out_illegal));

  imm_gen_pipe #(.XLEN(64), .PIPE_STAGES(2), .TAG_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .ExtenSel(b_sel), .imm_in(b_imm_in), .in_tag(b_in_tag), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_imm(b_out_imm), .out_tag(b_out_tag), .out_illegal(b_out_illegal));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // Reference immediate, computed from the full 32-bit instruction word using the ISA field layout.
  function automatic exp_t model(input logic [2:0] sel, input logic [24:0] f, input logic [4:0] tag);
    exp_t               e;
    logic [31:0]        instr;
    logic signed [63:0] sx, t;
    logic [63:0]        v;
    instr = {f, 7'b0};
    sx    = {{32{instr[31]}}, instr};
    v     = '0;
    case (sel)
      3'd0: begin t = sx >>> 20; v = t; end
      3'd1: begin t = sx >>> 20; v = (t & ~64'h1F) | 64'(instr[11:7]); end
      3'd2: begin
        t = sx >>> 19;
        v = (t & ~64'hFFF) | (64'(instr[7]) << 11) | (64'(instr[30:25]) << 5) | (64'(instr[11:8]) << 1);
      end
      3'd3: begin v = sx & ~64'hFFF; end
      3'd4: begin
        t = sx >>> 11;
        v = (t & ~64'hFFFFF) | (64'(instr[19:12]) << 12) | (64'(instr[20]) << 11) | (64'(instr[30:21]) << 1);
      end
      3'd5: begin v = 64'(instr[19:15]); end
      default: v = '0;
    endcase
    e.imm = v;
    e.tag = tag;
    e.ill = (sel >= 3'd6);
    return e;
  endfunction

  // Empties both pipelines with a one-cycle flush and leaves inputs idle.
  task automatic drain_all;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    a_flush = 1'b1; b_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0; b_flush = 1'b0;
  endtask

  // Reset values, asynchronous assertion mid-stream, and acceptance right after release.
  task automatic test_reset;
    rst_n = 1'b0;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_sel = 3'd0; a_imm_in = '0; a_in_tag = '0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_sel = 3'd0; b_imm_in = '0; b_in_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_a_valid got %0b want 0", a_out_valid); end
    n_tests++; if (a_out_imm !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_a_imm got %h want 0", a_out_imm); end
    n_tests++; if (a_out_tag !== 5'h0) begin n_fail++; $display("[TB] FAIL reset_a_tag got %h want 0", a_out_tag); end
    n_tests++; if (a_out_illegal !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_a_illegal got %0b want 0", a_out_illegal); end
    n_tests++; if (b_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_b_valid got %0b want 0", b_out_valid); end
    n_tests++; if (b_out_imm !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_b_imm got %h want 0", b_out_imm); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_sel = 3'd0; a_imm_in = 25'h1FFE000; a_in_tag = 5'd3;
    @(posedge clk); #2;
    n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_reset_valid got %0b want 1", a_out_valid); end
    n_tests++; if (a_out_imm !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL pre_reset_imm got %h want ffffffff", a_out_imm); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset_valid got %0b want 0", a_out_valid); end
    n_tests++; if (a_out_imm !== 32'h0) begin n_fail++; $display("[TB] FAIL async_reset_imm got %h want 0", a_out_imm); end
    n_tests++; if (a_out_tag !== 5'h0) begin n_fail++; $display("[TB] FAIL async_reset_tag got %h want 0", a_out_tag); end
    a_sel = 3'd3; a_imm_in = 25'h1000020; a_in_tag = 5'd7;
    @(posedge clk); @(negedge clk);
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL held_reset_valid got %0b want 0", a_out_valid); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL post_release_valid got %0b want 1", a_out_valid); end
    n_tests++; if (a_out_imm !== 32'h80001000) begin n_fail++; $display("[TB] FAIL post_release_imm got %h want 80001000", a_out_imm); end
    n_tests++; if (a_out_tag !== 5'd7) begin n_fail++; $display("[TB] FAIL post_release_tag got %0d want 7", a_out_tag); end
    a_in_valid = 1'b0;
    drain_all;
  endtask

  // Every ExtenSel code on the 32-bit instance, then a random back-to-back stream against the model.
  task automatic test_decode32;
    logic [2:0]  sels [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [24:0] imms [8] = '{25'h1FFE000, 25'h1FC001F, 25'h0000001, 25'h1000020,
                              25'h0002000, 25'h0001500, 25'h1FFFFFF, 25'h0ABCDEF};
    logic [31:0] exps [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000800, 32'h80001000,
                              32'h00000800, 32'h00000015, 32'h0, 32'h0};
    logic        ills [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  rs [24];
    logic [24:0] ri [24];
    exp_t        e;
    drain_all;
    for (int k = 0; k < 8; k++) begin
      a_in_valid = 1'b1; a_sel = sels[k]; a_imm_in = imms[k]; a_in_tag = 5'(k + 1);
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL dec_valid sel=%0d got %0b want 1", sels[k], a_out_valid); end
      n_tests++; if (a_out_imm !== exps[k]) begin n_fail++; $display("[TB] FAIL dec_imm sel=%0d got %h want %h", sels[k], a_out_imm, exps[k]); end
      n_tests++; if (a_out_illegal !== ills[k]) begin n_fail++; $display("[TB] FAIL dec_illegal sel=%0d got %0b want %0b", sels[k], a_out_illegal, ills[k]); end
      n_tests++; if (a_out_tag !== 5'(k + 1)) begin n_fail++; $display("[TB] FAIL dec_tag sel=%0d got %0d want %0d", sels[k], a_out_tag, k + 1); end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 24; k++) begin
      rs[k] = 3'($urandom_range(0, 7));
      ri[k] = 25'($urandom);
    end
    a_in_valid = 1'b1; a_sel = rs[0]; a_imm_in = ri[0]; a_in_tag = 5'd0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (c + 1 < 24) begin
        a_sel = rs[c+1]; a_imm_in = ri[c+1]; a_in_tag = 5'(c + 1);
      end else begin
        a_in_valid = 1'b0;
      end
      @(negedge clk);
      n_tests++; if (a_out_valid !== (c < 24)) begin n_fail++; $display("[TB] FAIL stream32_valid c=%0d got %0b want %0b", c, a_out_valid, c < 24); end
      if (c < 24) begin
        e = model(rs[c], ri[c], 5'(c));
        n_tests++;
        if ({a_out_imm, a_out_tag, a_out_illegal} !== {e.imm[31:0], e.tag, e.ill}) begin
          n_fail++;
          $display("[TB] FAIL stream32_data c=%0d got imm=%h tag=%0d ill=%0b want imm=%h tag=%0d ill=%0b",
                   c, a_out_imm, a_out_tag, a_out_illegal, e.imm[31:0], e.tag, e.ill);
        end
      end
    end
    drain_all;
  endtask

  // U-type on the 64-bit two-stage instance, including its two-edge latency.
  task automatic test_u64;
    drain_all;
    b_in_valid = 1'b1; b_sel = 3'd3; b_imm_in = 25'h1000020; b_in_tag = 5'd5;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (b_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL u64_early_valid got %0b want 0", b_out_valid); end
    @(posedge clk); @(negedge clk);
    n_tests++; if (b_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL u64_valid got %0b want 1", b_out_valid); end
    n_tests++; if (b_out_imm !== 64'hFFFFFFFF80001000) begin n_fail++; $display("[TB] FAIL u64_imm got %h want ffffffff80001000", b_out_imm); end
    n_tests++; if (b_out_tag !== 5'd5) begin n_fail++; $display("[TB] FAIL u64_tag got %0d want 5", b_out_tag); end
    @(posedge clk); #1;
  endtask

  // Eight consecutive requests through two stages: results two edges after first accept, in order.
  task automatic test_back_to_back;
    logic [2:0]  rs [8];
    logic [24:0] ri [8];
    exp_t        e;
    drain_all;
    for (int k = 0; k < 8; k++) begin
      rs[k] = 3'($urandom_range(0, 7));
      ri[k] = 25'($urandom);
    end
    b_in_valid = 1'b1; b_sel = rs[0]; b_imm_in = ri[0]; b_in_tag = 5'd0;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      if (c + 1 < 8) begin
        b_sel = rs[c+1]; b_imm_in = ri[c+1]; b_in_tag = 5'(c + 1);
      end else begin
        b_in_valid = 1'b0;
      end
      @(negedge clk);
      n_tests++; if (b_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_in_ready c=%0d got %0b want 1", c, b_in_ready); end
      n_tests++; if (b_out_valid !== (c >= 1 && c <= 8)) begin n_fail++; $display("[TB] FAIL b2b_valid c=%0d got %0b want %0b", c, b_out_valid, c >= 1 && c <= 8); end
      if (c >= 1 && c <= 8) begin
        e = model(rs[c-1], ri[c-1], 5'(c - 1));
        n_tests++;
        if ({b_out_imm, b_out_tag, b_out_illegal} !== {e.imm, e.tag, e.ill}) begin
          n_fail++;
          $display("[TB] FAIL b2b_data c=%0d got imm=%h tag=%0d want imm=%h tag=%0d", c, b_out_imm, b_out_tag, e.imm, e.tag);
        end
      end
    end
    drain_all;
  endtask

  // Back-pressure: two accepts fill the pipe, outputs hold, then push and pop together without a bubble.
  task automatic test_stall;
    int          accepts;
    logic [63:0] held_imm;
    logic [4:0]  held_tag;
    exp_t        e;
    drain_all;
    qb.delete();
    accepts = 0;
    held_imm = '0; held_tag = '0;
    b_out_ready = 1'b0; b_in_valid = 1'b1;
    b_sel = 3'($urandom_range(0, 5)); b_imm_in = 25'($urandom); b_in_tag = 5'd0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) begin
        held_imm = b_out_imm; held_tag = b_out_tag;
      end else if (c > 2) begin
        n_tests++; if ({b_out_imm, b_out_tag} !== {held_imm, held_tag}) begin n_fail++; $display("[TB] FAIL stall_hold c=%0d got %h/%0d want %h/%0d", c, b_out_imm, b_out_tag, held_imm, held_tag); end
      end
      if (b_in_valid && b_in_ready) begin
        accepts++;
        qb.push_back(model(b_sel, b_imm_in, b_in_tag));
      end
      @(posedge clk); #1;
      b_sel = 3'($urandom_range(0, 7)); b_imm_in = 25'($urandom); b_in_tag = 5'(c + 1);
    end
    @(negedge clk);
    n_tests++; if (accepts != 2) begin n_fail++; $display("[TB] FAIL stall_accepts got %0d want 2", accepts); end
    n_tests++; if (b_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_in_ready got %0b want 0", b_in_ready); end
    n_tests++; if (b_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_out_valid got %0b want 1", b_out_valid); end
    n_tests++; if (b_out_imm !== held_imm) begin n_fail++; $display("[TB] FAIL stall_final_hold got %h want %h", b_out_imm, held_imm); end
    @(posedge clk); #1;
    b_out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c >= 6) b_in_valid = 1'b0;
      @(negedge clk);
      if (c < 6) begin
        n_tests++; if (b_in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL pushpop_in_ready c=%0d got %0b want 1", c, b_in_ready); end
        n_tests++; if (b_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL pushpop_bubble c=%0d got %0b want 1", c, b_out_valid); end
      end
      if (b_out_valid && b_out_ready && qb.size() != 0) begin
        e = qb.pop_front();
        n_tests++;
        if ({b_out_imm, b_out_tag, b_out_illegal} !== {e.imm, e.tag, e.ill}) begin
          n_fail++;
          $display("[TB] FAIL pushpop_data c=%0d got imm=%h tag=%0d want imm=%h tag=%0d", c, b_out_imm, b_out_tag, e.imm, e.tag);
        end
      end
      if (b_in_valid && b_in_ready) qb.push_back(model(b_sel, b_imm_in, b_in_tag));
      @(posedge clk); #1;
      b_sel = 3'($urandom_range(0, 7)); b_imm_in = 25'($urandom); b_in_tag = 5'(c + 10);
    end
    @(negedge clk);
    n_tests++; if (qb.size() != 0) begin n_fail++; $display("[TB] FAIL stall_drain left=%0d want 0", qb.size()); end
    n_tests++; if (b_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_drain_valid got %0b want 0", b_out_valid); end
    drain_all;
  endtask

  // Flush with the pipe full and a request waiting: nothing emerges, and the next request flows normally.
  task automatic test_flush;
    drain_all;
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_sel = 3'd0; b_imm_in = 25'h1FFE000; b_in_tag = 5'd10;
    @(posedge clk); #1;
    b_imm_in = 25'h0002000; b_in_tag = 5'd11;
    @(posedge clk); #1;
    b_in_tag = 5'd12;
    a_in_valid = 1'b1; a_sel = 3'd0; a_imm_in = 25'h0002000; a_in_tag = 5'd20; a_out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (b_in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_full_ready got %0b want 0", b_in_ready); end
    n_tests++; if (b_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_full_valid got %0b want 1", b_out_valid); end
    b_flush = 1'b1; a_flush = 1'b1;
    @(posedge clk); #1;
    b_flush = 1'b0; a_flush = 1'b0; b_in_valid = 1'b0; a_in_valid = 1'b0; b_out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (b_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_b_valid got %0b want 0", b_out_valid); end
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_a_discard got %0b want 0", a_out_valid); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); @(negedge clk);
      n_tests++; if (b_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_ghost c=%0d got %0b want 0", c, b_out_valid); end
    end
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_sel = 3'd0; b_imm_in = 25'h0002000; b_in_tag = 5'd13;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (b_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL post_flush_early got %0b want 0", b_out_valid); end
    @(posedge clk); @(negedge clk);
    n_tests++; if (b_out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL post_flush_valid got %0b want 1", b_out_valid); end
    n_tests++; if (b_out_imm !== 64'h1) begin n_fail++; $display("[TB] FAIL post_flush_imm got %h want 1", b_out_imm); end
    n_tests++; if (b_out_tag !== 5'd13) begin n_fail++; $display("[TB] FAIL post_flush_tag got %0d want 13", b_out_tag); end
    @(posedge clk); #1;
  endtask

  // Random valid/ready/flush traffic on both instances, scored against per-instance queues.
  task automatic test_random_stream;
    exp_t        e;
    logic        a_hold, b_hold;
    logic [31:0] a_himm;
    logic [63:0] b_himm;
    logic [4:0]  a_htag, b_htag;
    drain_all;
    qa.delete(); qb.delete();
    a_hold = 1'b0; b_hold = 1'b0;
    a_himm = '0; b_himm = '0; a_htag = '0; b_htag = '0;
    for (int c = 0; c < 310; c++) begin
      @(posedge clk); #1;
      if (c < 300) begin
        a_in_valid = ($urandom_range(0, 3) != 0); a_out_ready = ($urandom_range(0, 3) != 0);
        a_flush = ($urandom_range(0, 39) == 0);
        a_sel = 3'($urandom_range(0, 7)); a_imm_in = 25'($urandom); a_in_tag = 5'($urandom);
        b_in_valid = ($urandom_range(0, 3) != 0); b_out_ready = ($urandom_range(0, 3) != 0);
        b_flush = ($urandom_range(0, 39) == 0);
        b_sel = 3'($urandom_range(0, 7)); b_imm_in = 25'($urandom); b_in_tag = 5'($urandom);
      end else begin
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_flush = 1'b0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_flush = 1'b0;
      end
      @(negedge clk);
      n_tests++; if (a_in_ready !== (qa.size() < 1 || a_out_ready)) begin n_fail++; $display("[TB] FAIL rnd_a_ready c=%0d got %0b", c, a_in_ready); end
      n_tests++; if (a_out_valid !== (qa.size() != 0)) begin n_fail++; $display("[TB] FAIL rnd_a_valid c=%0d got %0b want %0b", c, a_out_valid, qa.size() != 0); end
      if (a_hold) begin
        n_tests++; if ({a_out_imm, a_out_tag} !== {a_himm, a_htag}) begin n_fail++; $display("[TB] FAIL rnd_a_hold c=%0d got %h want %h", c, a_out_imm, a_himm); end
      end
      if (a_out_valid && a_out_ready && qa.size() != 0) begin
        e = qa.pop_front();
        n_tests++;
        if ({a_out_imm, a_out_tag, a_out_illegal} !== {e.imm[31:0], e.tag, e.ill}) begin
          n_fail++; $display("[TB] FAIL rnd_a_data c=%0d got %h/%0d want %h/%0d", c, a_out_imm, a_out_tag, e.imm[31:0], e.tag);
        end
      end
      a_hold = a_out_valid && !a_out_ready && !a_flush;
      a_himm = a_out_imm; a_htag = a_out_tag;
      if (a_flush) qa.delete();
      else if (a_in_valid && a_in_ready) qa.push_back(model(a_sel, a_imm_in, a_in_tag));

      n_tests++; if (b_in_ready !== (qb.size() < 2 || b_out_ready)) begin n_fail++; $display("[TB] FAIL rnd_b_ready c=%0d got %0b", c, b_in_ready); end
      if (qb.size() == 0 || qb.size() == 2) begin
        n_tests++; if (b_out_valid !== (qb.size() == 2)) begin n_fail++; $display("[TB] FAIL rnd_b_valid c=%0d got %0b", c, b_out_valid); end
      end
      if (b_hold) begin
        n_tests++; if ({b_out_imm, b_out_tag} !== {b_himm, b_htag}) begin n_fail++; $display("[TB] FAIL rnd_b_hold c=%0d got %h want %h", c, b_out_imm, b_himm); end
      end
      if (b_out_valid && b_out_ready) begin
        n_tests++;
        if (qb.size() == 0) begin
          n_fail++; $display("[TB] FAIL rnd_b_extra c=%0d got tag=%0d want none", c, b_out_tag);
        end else begin
          e = qb.pop_front();
          if ({b_out_imm, b_out_tag, b_out_illegal} !== {e.imm, e.tag, e.ill}) begin
            n_fail++; $display("[TB] FAIL rnd_b_data c=%0d got %h/%0d want %h/%0d", c, b_out_imm, b_out_tag, e.imm, e.tag);
          end
        end
      end
      b_hold = b_out_valid && !b_out_ready && !b_flush;
      b_himm = b_out_imm; b_htag = b_out_tag;
      if (b_flush) qb.delete();
      else if (b_in_valid && b_in_ready) qb.push_back(model(b_sel, b_imm_in, b_in_tag));
    end
    n_tests++; if (qa.size() != 0) begin n_fail++; $display("[TB] FAIL rnd_a_leftover got %0d want 0", qa.size()); end
    n_tests++; if (qb.size() != 0) begin n_fail++; $display("[TB] FAIL rnd_b_leftover got %0d want 0", qb.size()); end
  endtask

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    test_reset;
    test_decode32;
    test_u64;
    test_back_to_back;
    test_stall;
    test_flush;
    test_random_stream;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
